// File: rtl/bicubic_window_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : bicubic_window_feeder_if
//  Purpose  : Bundles the pixel-stream, geometry and column-output signals of
//             bicubic_window_feeder.
//  Modports : master - pixel source / column consumer side
//             slave  - the feeder itself
//  Revision : 1.0 - initial release
// ============================================================================
interface bicubic_window_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 64,
  parameter int ADDR_W     = $clog2(MAX_WIDTH)
);
  logic                  frame_start;
  logic [ADDR_W:0]       line_width;
  logic [10:0]           frame_height;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] row0_out;
  logic [DATA_WIDTH-1:0] row1_out;
  logic [DATA_WIDTH-1:0] row2_out;
  logic [DATA_WIDTH-1:0] row3_out;
  logic                  shift_window;
  logic                  window_valid;
  logic [ADDR_W-1:0]     out_col;
  logic [10:0]           out_row;
  logic                  frame_done;

  modport master (
    output frame_start, line_width, frame_height, in_data, in_valid,
    input  in_ready, row0_out, row1_out, row2_out, row3_out,
    input  shift_window, window_valid, out_col, out_row, frame_done
  );

  modport slave (
    input  frame_start, line_width, frame_height, in_data, in_valid,
    output in_ready, row0_out, row1_out, row2_out, row3_out,
    output shift_window, window_valid, out_col, out_row, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/bicubic_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : bicubic_window_feeder
//  Purpose  : Raster-order pixel stream to 4-pixel vertical columns for
//             bicubic_core. Keeps three previous lines in line buffers,
//             tracks frame geometry, qualifies full 4x4 windows and flags
//             end of frame.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - slave modport: frame_start/line_width/frame_height,
//                    in_data/in_valid/in_ready, row0..row3_out,
//                    shift_window, window_valid, out_col, out_row,
//                    frame_done
//  Revision : 1.0 - initial release
// ============================================================================
module bicubic_window_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 64,
  parameter int ADDR_W     = $clog2(MAX_WIDTH)
) (
  input  wire logic                clk,
  input  wire logic                rst,
  bicubic_window_feeder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   ONE_W  = 1;
  localparam logic [ADDR_W-1:0] COL_3  = 3;
  localparam logic [10:0]       ROW_3  = 11'd3;

  state_t                state_q;
  logic [ADDR_W-1:0]     col_q;
  logic [10:0]           row_q;
  logic [ADDR_W:0]       width_q;
  logic [10:0]           height_q;

  logic [DATA_WIDTH-1:0] row0_q, row1_q, row2_q, row3_q;
  logic [ADDR_W-1:0]     out_col_q;
  logic [10:0]           out_row_q;
  logic                  shift_q, wvalid_q, done_q;

  // LA = line y-1, LB = line y-2, LC = line y-3; never cleared, stale
  // contents are masked by window_valid.
  logic [DATA_WIDTH-1:0] la_q [MAX_WIDTH];
  logic [DATA_WIDTH-1:0] lb_q [MAX_WIDTH];
  logic [DATA_WIDTH-1:0] lc_q [MAX_WIDTH];

  logic in_ready;
  logic accept;
  logic col_last;
  logic row_last;

  // frame_start blocks acceptance so a restart never mixes with a pixel.
  assign in_ready = (state_q == S_ACTIVE) && !bus.frame_start;
  assign accept   = bus.in_valid && in_ready;
  assign col_last = ({1'b0, col_q} == (width_q - ONE_W));
  assign row_last = (row_q == (height_q - 11'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      width_q   <= '0;
      height_q  <= '0;
      row0_q    <= '0;
      row1_q    <= '0;
      row2_q    <= '0;
      row3_q    <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      shift_q   <= 1'b0;
      wvalid_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shift_q  <= accept;
      wvalid_q <= accept && (row_q >= ROW_3) && (col_q >= COL_3);
      done_q   <= accept && col_last && row_last;

      if (bus.frame_start) begin
        state_q  <= S_ACTIVE;
        col_q    <= '0;
        row_q    <= '0;
        width_q  <= bus.line_width;
        height_q <= bus.frame_height;
      end else if (accept) begin
        // Reads see pre-write buffer contents (writes land on the same edge).
        row3_q    <= bus.in_data;
        row2_q    <= la_q[col_q];
        row1_q    <= lb_q[col_q];
        row0_q    <= lc_q[col_q];
        out_col_q <= col_q;
        out_row_q <= row_q;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + 11'd1;
          if (row_last) state_q <= S_DONE;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lc_q[col_q] <= lb_q[col_q];
      lb_q[col_q] <= la_q[col_q];
      la_q[col_q] <= bus.in_data;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.row0_out     = row0_q;
  assign bus.row1_out     = row1_q;
  assign bus.row2_out     = row2_q;
  assign bus.row3_out     = row3_q;
  assign bus.shift_window = shift_q;
  assign bus.window_valid = wvalid_q;
  assign bus.out_col      = out_col_q;
  assign bus.out_row      = out_row_q;
  assign bus.frame_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bicubic_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bicubic_window_feeder
//  Purpose  : Directed self-checking bench for bicubic_window_feeder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bicubic_window_feeder;

  localparam int DW = 8;
  localparam int MW = 64;
  localparam int AW = $clog2(MW);

  logic clk;
  logic rst;

  bicubic_window_feeder_if #(.DATA_WIDTH(DW), .MAX_WIDTH(MW), .ADDR_W(AW)) bus ();

  bicubic_window_feeder #(.DATA_WIDTH(DW), .MAX_WIDTH(MW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int wv_count = 0;
  int shift_count = 0;
  logic [7:0] last_v = 8'h00;
  int last_c = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pixel value for (row, col) in a frame using offset s.
  function automatic logic [7:0] val(input int r, input int c, input int s);
    return 8'(r * 16 + c + s);
  endfunction

  task automatic start_frame(input int w, input int h);
    bus.frame_start  = 1'b1;
    bus.line_width   = (AW+1)'(w);
    bus.frame_height = 11'(h);
    #1;
    check_val("fs_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
  endtask

  // Present one pixel, take it on the next edge and check the emitted column.
  task automatic feed(input int r, input int c, input bit last, input int s);
    logic [7:0] v;
    v = val(r, c, s);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    #1;
    check_val("in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_val("shift_window", 32'(bus.shift_window), 32'd1);
    check_val("out_row", 32'(bus.out_row), 32'(r));
    check_val("out_col", 32'(bus.out_col), 32'(c));
    check_val("window_valid", 32'(bus.window_valid), 32'((r >= 3) && (c >= 3)));
    check_val("frame_done", 32'(bus.frame_done), 32'(last));
    check_val("row3_out", 32'(bus.row3_out), 32'(v));
    if (r >= 1) check_val("row2_out", 32'(bus.row2_out), 32'(val(r-1, c, s)));
    if (r >= 2) check_val("row1_out", 32'(bus.row1_out), 32'(val(r-2, c, s)));
    if (r >= 3) check_val("row0_out", 32'(bus.row0_out), 32'(val(r-3, c, s)));
    wv_count    += int'(bus.window_valid);
    shift_count += int'(bus.shift_window);
    last_v = v;
    last_c = c;
  endtask

  task automatic run_frame(input int w, input int h, input int s);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        feed(r, c, (r == h-1) && (c == w-1), s);
  endtask

  initial begin
    rst              = 1'b1;
    bus.frame_start  = 1'b0;
    bus.line_width   = '0;
    bus.frame_height = '0;
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;

    // Reset values
    #1;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_shift", 32'(bus.shift_window), 32'd0);
    check_val("rst_out_col", 32'(bus.out_col), 32'd0);
    check_val("rst_row3", 32'(bus.row3_out), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_val("idle_no_accept", 32'(bus.shift_window), 32'd0);

    // Asynchronous reset mid-stream
    start_frame(4, 4);
    feed(0, 0, 1'b0, 100);
    feed(0, 1, 1'b0, 100);
    feed(0, 2, 1'b0, 100);
    rst = 1'b1;
    #1;
    check_val("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("arst_shift", 32'(bus.shift_window), 32'd0);
    check_val("arst_frame_done", 32'(bus.frame_done), 32'd0);
    check_val("arst_row0", 32'(bus.row0_out), 32'd0);
    check_val("arst_row1", 32'(bus.row1_out), 32'd0);
    check_val("arst_row2", 32'(bus.row2_out), 32'd0);
    check_val("arst_row3", 32'(bus.row3_out), 32'd0);
    check_val("arst_out_col", 32'(bus.out_col), 32'd0);
    #2 rst = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check_val("arst_idle_ready", 32'(bus.in_ready), 32'd0);
    check_val("arst_idle_shift", 32'(bus.shift_window), 32'd0);
    bus.in_valid = 1'b0;

    // Column contents, 4x4, gap-free
    start_frame(4, 4);
    wv_count = 0;
    run_frame(4, 4, 0);
    check_val("f1_wv_count", 32'(wv_count), 32'd1);
    bus.in_valid = 1'b1;
    #1;
    check_val("f1_done_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_val("f1_post_shift", 32'(bus.shift_window), 32'd0);
    check_val("f1_post_done", 32'(bus.frame_done), 32'd0);
    check_val("f1_hold_row3", 32'(bus.row3_out), 32'h33);
    check_val("f1_hold_row0", 32'(bus.row0_out), 32'h03);

    // Same frame with random bubbles
    start_frame(4, 4);
    shift_count = 0;
    begin
      int acc = 0;
      int cyc = 0;
      while (acc < 16 && cyc < 200) begin
        cyc++;
        if ($urandom_range(0, 1) == 1) begin
          feed(acc / 4, acc % 4, acc == 15, 0);
          acc++;
        end else begin
          bus.in_valid = 1'b0;
          @(posedge clk); #1;
          check_val("bub_shift", 32'(bus.shift_window), 32'd0);
          check_val("bub_wv", 32'(bus.window_valid), 32'd0);
          check_val("bub_hold_row3", 32'(bus.row3_out), 32'(last_v));
          check_val("bub_hold_col", 32'(bus.out_col), 32'(last_c));
          shift_count += int'(bus.shift_window);
        end
      end
      check_val("bub_accepted", 32'(acc), 32'd16);
    end
    repeat (3) begin
      @(posedge clk); #1;
      shift_count += int'(bus.shift_window);
    end
    check_val("bub_shift_count", 32'(shift_count), 32'd16);

    // Full-width lines
    start_frame(64, 6);
    wv_count = 0;
    run_frame(64, 6, 7);
    check_val("fw_wv_count", 32'(wv_count), 32'd183);
    check_val("fw_row0_5_63", 32'(bus.row0_out), 32'(val(2, 63, 7)));

    // Restart mid-frame with in_valid high
    start_frame(4, 4);
    for (int k = 0; k < 6; k++) feed(k / 4, k % 4, 1'b0, 50);
    bus.frame_start  = 1'b1;
    bus.line_width   = 5'(4);
    bus.frame_height = 11'd4;
    bus.in_valid     = 1'b1;
    bus.in_data      = 8'hEE;
    #1;
    check_val("rs_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("rs_prev_shift", 32'(bus.shift_window), 32'd1);
    check_val("rs_prev_row", 32'(bus.out_row), 32'd1);
    check_val("rs_prev_col", 32'(bus.out_col), 32'd1);
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    check_val("rs_no_accept", 32'(bus.shift_window), 32'd0);
    run_frame(4, 4, 80);

    // Second frame after DONE, width 5
    start_frame(5, 4);
    wv_count = 0;
    run_frame(5, 4, 3);
    check_val("f2_wv_count", 32'(wv_count), 32'd2);
    #1;
    check_val("f2_done_ready", 32'(bus.in_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
